// File: rtl/cpu_types_pkg.sv
//------------------------------------------------------------------------------
// Module   : cpu_types_pkg
// Purpose  : Shared types and constants for the MIPS pipeline:
//            - 32-bit word type
//            - fetch-stage state encoding
//            - PC increment
//            - word-alignment helper
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t PC_INCR = 32'd4;

  // Instruction addresses are always word aligned; the low two bits of a
  // jump/branch target are dropped.
  function automatic word_t word_align(input word_t addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_if.sv
//------------------------------------------------------------------------------
// Module   : fetch_if
// Purpose  : Groups the fetch-stage signals for integration code.
//            The fetch modport gives the fetch-unit view of the bundle.
//            The performance counters are present only when FETCH_PERF_EN
//            is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_if
  import cpu_types_pkg::*;
(
  input logic CLK,
  input logic RST
);

  logic  ihit;
  word_t imemload;
  logic  imemREN;
  word_t imemaddr;
  logic  stall;
  logic  flush;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  word_t instr_out;
  word_t npc_out;
  logic  instr_valid;
`ifdef FETCH_PERF_EN
  word_t fetch_count;
  word_t stall_count;
`endif

  modport fetch (
    input  CLK, RST, ihit, imemload, stall, flush, redirect, redirect_pc, halt,
`ifdef FETCH_PERF_EN
    output fetch_count, stall_count,
`endif
    output imemREN, imemaddr, instr_out, npc_out, instr_valid
  );

endinterface

`default_nettype wire

// File: rtl/fetch_pc_reg.sv
//------------------------------------------------------------------------------
// Module   : fetch_pc_reg
// Purpose  : Program counter with its priority next-PC selection and the
//            +4 incrementer.
//            Selection priority (highest first): freeze, redirect, advance.
// Ports    : CLK, RST (async, active-high)
//            freeze      - hold the PC (halt / halted)
//            redirect    - load the aligned redirect_pc
//            redirect_pc - branch/jump target
//            advance     - step the PC by 4 (a fetch completed)
//            pc          - current PC
//            pc_plus4    - PC + 4, modulo 2^32
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_pc_reg
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC0 = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        freeze,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  word_t pc_next;

  // Plain 32-bit add: 0xFFFFFFFC wraps to 0.
  assign pc_plus4 = pc + PC_INCR;

  always_comb begin
    pc_next = pc;
    if (freeze) begin
      pc_next = pc;
    end else if (redirect) begin
      pc_next = word_align(redirect_pc);
    end else if (advance) begin
      pc_next = pc_plus4;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc <= PC0;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage feeding the IF/ID register.
//            - Owns the PC and issues imem read requests.
//            - Honours halt, redirect, flush and stall, in that priority.
//            - A word returned while IF/ID is stalled is parked in a
//              one-entry buffer (HOLD state) and delivered when the stall
//              drops.
// Ports    : CLK, RST (async, active-high)
//            imem side  : ihit, imemload, imemREN, imemaddr
//            control    : stall, flush, redirect, redirect_pc, halt
//            IF/ID side : instr_out, npc_out, instr_valid
// Macro    : FETCH_PERF_EN adds fetch_count / stall_count outputs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC0 = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr_out,
  output logic [31:0] npc_out,
  output logic        instr_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  fetch_state_t state, state_d;
  word_t        pc, pc_plus4;
  word_t        buf_instr, buf_instr_d;
  word_t        buf_npc, buf_npc_d;
  word_t        instr_d, npc_d;
  logic         valid_d;
  logic         pc_freeze;
  logic         pc_advance;

  // Once halt is seen the PC never moves again until reset.
  assign pc_freeze  = halt || (state == HALTED);
  // A completed fetch always consumes its address, even when the word is
  // dropped by a flush or parked by a stall; redirect outranks it inside
  // the PC register.
  assign pc_advance = (state == FETCH) && ihit;

  fetch_pc_reg #(
    .PC0 (PC0)
  ) u_pc_reg (
    .CLK         (CLK),
    .RST         (RST),
    .freeze      (pc_freeze),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .advance     (pc_advance),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  assign imemaddr = pc;
  assign imemREN  = (state == FETCH) && !RST;

  always_comb begin
    state_d     = state;
    instr_d     = instr_out;
    npc_d       = npc_out;
    valid_d     = instr_valid;
    buf_instr_d = buf_instr;
    buf_npc_d   = buf_npc;

    if (halt || (state == HALTED)) begin
      state_d     = HALTED;
      valid_d     = 1'b0;
      buf_instr_d = '0;
      buf_npc_d   = '0;
    end else if (redirect || flush) begin
      state_d     = FETCH;
      valid_d     = 1'b0;
      buf_instr_d = '0;
      buf_npc_d   = '0;
    end else begin
      case (state)
        FETCH: begin
          if (ihit && stall) begin
            buf_instr_d = imemload;
            buf_npc_d   = pc_plus4;
            state_d     = HOLD;
          end else if (ihit) begin
            instr_d = imemload;
            npc_d   = pc_plus4;
            valid_d = 1'b1;
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_d = buf_instr;
            npc_d   = buf_npc;
            valid_d = 1'b1;
            state_d = FETCH;
          end
        end
        default: begin
          state_d = HALTED;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= FETCH;
      instr_out   <= '0;
      npc_out     <= '0;
      instr_valid <= 1'b0;
      buf_instr   <= '0;
      buf_npc     <= '0;
    end else begin
      state       <= state_d;
      instr_out   <= instr_d;
      npc_out     <= npc_d;
      instr_valid <= valid_d;
      buf_instr   <= buf_instr_d;
      buf_npc     <= buf_npc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic deliver;

  // A delivery happens only on the two paths that write instr_valid to 1;
  // a valid bit merely held through a stall is not counted again.
  assign deliver = !halt && (state != HALTED) && !redirect && !flush && !stall &&
                   (((state == FETCH) && ihit) || (state == HOLD));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (deliver) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (stall && (state != HALTED)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire
